// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_pkg
//  Description : Shared register map, mode encoding and helpers for int_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    // Hardware supports at most six CPU interrupt lines.
    localparam int          c_MAX_SRC      = 6;
    localparam logic [31:0] c_DEFAULT_BASE = 32'h0000_7F20;

    // Byte offsets of the registers inside the 16-byte window.
    localparam logic [3:0] c_OFF_PEND   = 4'h0;
    localparam logic [3:0] c_OFF_MASK   = 4'h4;
    localparam logic [3:0] c_OFF_MODE   = 4'h8;
    localparam logic [3:0] c_OFF_STATUS = 4'hC;

    // Word select, taken from address bits [3:2].
    typedef enum logic [1:0] {
        REG_PEND   = c_OFF_PEND[3:2],
        REG_MASK   = c_OFF_MASK[3:2],
        REG_MODE   = c_OFF_MODE[3:2],
        REG_STATUS = c_OFF_STATUS[3:2]
    } reg_sel_e;

    typedef enum logic {
        MODE_EDGE  = 1'b0,
        MODE_LEVEL = 1'b1
    } irq_mode_e;

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [c_MAX_SRC-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = c_MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_if
//  Description : CPU data-bus slave port of the interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface int_ctrl_if;

    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_byteen,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_byteen,
        output bus_rdata
    );

endinterface
`default_nettype wire

// File: rtl/int_src_cell.sv
`default_nettype none
// ============================================================================
//  Module      : int_src_cell
//  Description : One interrupt source: optional synchronizer, previous-sample
//                flop and pending bit with edge/level capture.
//                Build option INT_CTRL_SYNC_EN adds a 2-flop input synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_src_cell
    import int_ctrl_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      i_src,
    input  wire irq_mode_e i_mode,
    input  wire logic      i_clr,
    output logic           o_pend
);

    logic w_src;
    logic w_rise;
    logic r_prev;
    logic r_pend;

`ifdef INT_CTRL_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_src};
        end
    end

    assign w_src = r_sync[1];
`else
    assign w_src = i_src;
`endif

    assign w_rise = w_src & ~r_prev;

    // In edge mode a new edge beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= w_src;
            if (i_mode == MODE_LEVEL) begin
                r_pend <= w_src;
            end else begin
                r_pend <= w_rise | (r_pend & ~i_clr);
            end
        end
    end

    assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Memory-mapped interrupt controller with PEND/MASK/MODE/STATUS
//                registers and masked interrupt outputs to the CPU.
//                Build option INT_CTRL_SYNC_EN synchronizes irq_src inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NSRC = 6,
    parameter logic [31:0] BASE = c_DEFAULT_BASE
)(
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [NSRC-1:0] irq_src,
    int_ctrl_if.slave            bus,
    output logic [5:0]           hw_int
);

    logic [31:0]           w_off;
    logic                  w_hit;
    logic                  w_wr0;
    reg_sel_e              w_sel;
    logic [NSRC-1:0]       w_clr;
    logic [NSRC-1:0]       w_pend;
    logic [NSRC-1:0]       w_act;
    logic [c_MAX_SRC-1:0]  w_act6;
    logic [31:0]           w_rdata;
    logic                  w_unused_bits;

    logic [NSRC-1:0]       r_mask;
    logic [NSRC-1:0]       r_mode;

    // Subtracting first keeps the range test correct even near the top of memory.
    assign w_off = bus.bus_addr - BASE;
    assign w_hit = (w_off[31:4] == 28'd0);
    assign w_sel = reg_sel_e'(bus.bus_addr[3:2]);
    assign w_wr0 = w_hit & bus.bus_byteen[0];
    assign w_clr = (w_wr0 && (w_sel == REG_PEND)) ? bus.bus_wdata[NSRC-1:0] : '0;

    assign w_unused_bits = ^{bus.bus_byteen[3:1], bus.bus_wdata[31:NSRC]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            r_mode <= '0;
        end else if (w_wr0) begin
            if (w_sel == REG_MASK) r_mask <= bus.bus_wdata[NSRC-1:0];
            if (w_sel == REG_MODE) r_mode <= bus.bus_wdata[NSRC-1:0];
        end
    end

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        int_src_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .i_src  (irq_src[gi]),
            .i_mode (irq_mode_e'(r_mode[gi])),
            .i_clr  (w_clr[gi]),
            .o_pend (w_pend[gi])
        );
    end

    assign w_act  = w_pend & r_mask;
    assign w_act6 = c_MAX_SRC'(w_act);
    assign hw_int = w_act6;

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (w_sel)
                REG_PEND:   w_rdata = 32'(w_pend);
                REG_MASK:   w_rdata = 32'(r_mask);
                REG_MODE:   w_rdata = 32'(r_mode);
                REG_STATUS: begin
                    w_rdata[31]  = |w_act;
                    w_rdata[2:0] = lowest_set(w_act6);
                end
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.bus_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Self-checking bench for int_ctrl: vector table, directed
//                multi-cycle sequences and randomized traffic vs. a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam int          NSRC   = 6;
    localparam logic [31:0] BASE   = 32'h0000_7F20;
    localparam logic [31:0] A_PEND = 32'h0000_7F20;
    localparam logic [31:0] A_MASK = 32'h0000_7F24;
    localparam logic [31:0] A_MODE = 32'h0000_7F28;
    localparam logic [31:0] A_STAT = 32'h0000_7F2C;
`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NSRC-1:0] irq_src = '0;
    logic [5:0]      hw_int;

    int_ctrl_if bus();

    int_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus),
        .hw_int  (hw_int)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: registers plus a delay line for the sampled sources.
    logic [5:0] m_pend, m_mask, m_mode, m_prev;
    logic [5:0] m_dly [0:1];

    typedef struct {
        logic [5:0]  src;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [5:0]  exp_hw;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        logic [5:0]  act;
        r = 32'd0;
        if ((a - BASE) < 32'd16) begin
            case (a[3:2])
                2'd0: r = 32'(m_pend);
                2'd1: r = 32'(m_mask);
                2'd2: r = 32'(m_mode);
                default: begin
                    act = m_pend & m_mask;
                    if (act != 6'd0) begin
                        r[31] = 1'b1;
                        for (int i = 0; i < 6; i++) begin
                            if (act[i]) begin
                                r[2:0] = 3'(i);
                                break;
                            end
                        end
                    end
                end
            endcase
        end
        return r;
    endfunction

    task automatic model_clear();
        m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0;
        m_dly[0] = '0; m_dly[1] = '0;
    endtask

    task automatic bus_set(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.bus_addr = a; bus.bus_wdata = d; bus.bus_byteen = be;
    endtask

    // One clock edge; the model advances with the inputs held across it.
    task automatic tick();
        logic [5:0] samp, clr, npend, nmask, nmode;
        logic       wr0;
        samp  = (LAT == 2) ? m_dly[1] : irq_src;
        wr0   = ((bus.bus_addr - BASE) < 32'd16) && bus.bus_byteen[0];
        clr   = (wr0 && bus.bus_addr[3:2] == 2'd0) ? bus.bus_wdata[5:0] : 6'd0;
        npend = (m_mode & samp) | (~m_mode & ((m_pend & ~clr) | (samp & ~m_prev)));
        nmask = (wr0 && bus.bus_addr[3:2] == 2'd1) ? bus.bus_wdata[5:0] : m_mask;
        nmode = (wr0 && bus.bus_addr[3:2] == 2'd2) ? bus.bus_wdata[5:0] : m_mode;
        m_dly[1] = m_dly[0];
        m_dly[0] = irq_src;
        @(posedge clk);
        #1;
        m_pend = npend; m_mask = nmask; m_mode = nmode; m_prev = samp;
    endtask

    task automatic check_outs(input string nm);
        chk($sformatf("%s_hw", nm), 32'(hw_int), 32'(m_pend & m_mask));
        chk($sformatf("%s_rd", nm), bus.bus_rdata, m_read(bus.bus_addr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_set(A_PEND, 32'd0, 4'd0);
        model_clear();
        do_reset();

`ifndef INT_CTRL_SYNC_EN
        // src, addr, wdata, byteen, expected hw_int, expected rdata
        tbl.push_back('{6'h00, A_STAT,       32'h0,        4'h0, 6'h00, 32'h0});
        tbl.push_back('{6'h00, A_MASK,       32'h01,       4'h1, 6'h00, 32'h01});
        tbl.push_back('{6'h01, A_PEND,       32'h0,        4'h0, 6'h01, 32'h01});
        tbl.push_back('{6'h00, A_PEND,       32'h0,        4'h0, 6'h01, 32'h01});
        tbl.push_back('{6'h00, A_PEND,       32'h01,       4'h1, 6'h00, 32'h00});
        tbl.push_back('{6'h00, A_MODE,       32'h02,       4'h1, 6'h00, 32'h02});
        tbl.push_back('{6'h00, A_MASK,       32'h02,       4'h1, 6'h00, 32'h02});
        tbl.push_back('{6'h02, A_PEND,       32'h0,        4'h0, 6'h02, 32'h02});
        tbl.push_back('{6'h02, A_PEND,       32'h02,       4'h1, 6'h02, 32'h02});
        tbl.push_back('{6'h00, A_PEND,       32'h0,        4'h0, 6'h00, 32'h00});
        tbl.push_back('{6'h14, A_PEND,       32'h0,        4'h0, 6'h00, 32'h14});
        tbl.push_back('{6'h14, A_MASK,       32'h3F,       4'h1, 6'h14, 32'h3F});
        tbl.push_back('{6'h14, A_STAT,       32'h0,        4'h0, 6'h14, 32'h8000_0002});
        tbl.push_back('{6'h14, A_MASK,       32'h10,       4'h1, 6'h10, 32'h10});
        tbl.push_back('{6'h14, A_STAT,       32'h0,        4'h0, 6'h10, 32'h8000_0004});
        tbl.push_back('{6'h14, A_STAT,       32'hFFFF_FFFF, 4'hF, 6'h10, 32'h8000_0004});
        tbl.push_back('{6'h1C, A_PEND,       32'h08,       4'h1, 6'h10, 32'h1C});
        tbl.push_back('{6'h1C, A_PEND,       32'h1C,       4'h1, 6'h00, 32'h00});
        tbl.push_back('{6'h00, 32'h0000_7F30, 32'h0,       4'h0, 6'h00, 32'h00});
        tbl.push_back('{6'h00, 32'h0000_7F34, 32'h0,       4'hF, 6'h00, 32'h00});
        tbl.push_back('{6'h00, 32'h0000_7F27, 32'h0,       4'h0, 6'h00, 32'h10});
        tbl.push_back('{6'h00, A_MASK,       32'h3F,       4'h2, 6'h00, 32'h10});
        tbl.push_back('{6'h00, 32'h0000_7F1F, 32'h0,       4'h0, 6'h00, 32'h00});
        tbl.push_back('{6'h00, 32'h0000_7F2F, 32'h0,       4'h0, 6'h00, 32'h00});
        foreach (tbl[i]) begin
            irq_src = tbl[i].src;
            bus_set(tbl[i].addr, tbl[i].wdata, tbl[i].be);
            tick();
            chk($sformatf("vec%0d_hw", i), 32'(hw_int), 32'(tbl[i].exp_hw));
            chk($sformatf("vec%0d_rd", i), bus.bus_rdata, tbl[i].exp_rd);
        end
`endif

        // Capture latency from a source edge to hw_int.
        irq_src = '0;
        do_reset();
        bus_set(A_MASK, 32'h01, 4'h1);
        tick();
        bus_set(A_PEND, 32'h0, 4'h0);
        tick(); tick();
        irq_src = 6'h01;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("lat%0d_hw0", k), 32'(hw_int[0]), 32'(k >= LAT));
            check_outs("lat");
        end

        // Edge to level: PEND reloads from the (now low) source.
        irq_src = '0;
        bus_set(A_MODE, 32'h01, 4'h1);
        tick();
        chk("e2l_hold_hw0", 32'(hw_int[0]), 32'd1);
        bus_set(A_PEND, 32'h0, 4'h0);
        for (int k = 0; k <= LAT; k++) begin
            tick();
            check_outs("e2l");
        end
        chk("e2l_drop_hw0", 32'(hw_int[0]), 32'd0);

        // Level to edge: current PEND is kept.
        irq_src = 6'h01;
        for (int k = 0; k <= LAT; k++) tick();
        chk("l2e_level_hw0", 32'(hw_int[0]), 32'd1);
        bus_set(A_MODE, 32'h00, 4'h1);
        tick();
        irq_src = '0;
        bus_set(A_PEND, 32'h0, 4'h0);
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            check_outs("l2e");
        end
        chk("l2e_keep_hw0", 32'(hw_int[0]), 32'd1);

        // Source already high when reset releases counts as an edge.
        irq_src = 6'h01;
        do_reset();
        bus_set(A_MASK, 32'h01, 4'h1);
        for (int k = 0; k <= LAT; k++) begin
            tick();
            check_outs("rel");
        end
        chk("rel_hw", 32'(hw_int), 32'h01);

        // Asynchronous reset in the middle of a clock period.
        irq_src = 6'h3F;
        bus_set(A_MASK, 32'h3F, 4'h1);
        for (int k = 0; k <= LAT; k++) tick();
        irq_src = '0;
        bus_set(A_PEND, 32'h0, 4'h0);
        tick();
        chk("mid_before_hw", 32'(hw_int), 32'h3F);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("mid_async_hw", 32'(hw_int), 32'h0);
        chk("mid_async_pend", bus.bus_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_set(A_MASK, 32'h0, 4'h0);
        #1;
        chk("mid_after_mask", bus.bus_rdata, 32'h0);
        bus_set(A_STAT, 32'h0, 4'h0);
        #1;
        chk("mid_after_stat", bus.bus_rdata, 32'h0);
        bus_set(A_PEND, 32'h0, 4'h0);
        #1;
        chk("mid_after_pend", bus.bus_rdata, 32'h0);

        // Randomized traffic against the reference model.
        irq_src = '0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0:       a = BASE - 32'($urandom_range(1, 8));
                1:       a = BASE + 32'd16 + 32'($urandom_range(0, 7));
                2:       a = $urandom;
                default: a = BASE + 32'($urandom_range(0, 15));
            endcase
            irq_src = irq_src ^ 6'($urandom & $urandom);
            bus_set(a, $urandom, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
            tick();
            check_outs($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
